// File: rtl/ball_frame_i2c_sender.sv
// Frame sequencer for the ball hand-off link: snapshots ball state on a trigger and drives a
// byte-level I2C master through START, address, 5 payload bytes and STOP, with NACK retry.
module ball_frame_i2c_sender #(
  parameter logic [6:0]  SLV_ADDR  = 7'h6C,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned N_BYTES   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ball_send_trigger,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_counter,
  input  logic       is_collusion,
  input  logic       ready,
  input  logic       tx_done,
  input  logic       nack,
  output logic       i2c_en,
  output logic       start,
  output logic       stop,
  output logic [7:0] tx_data,
  output logic       is_transfer,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int               IDX_W       = $clog2(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_BYTES - 1);
  localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRY);
  localparam logic [7:0]       ADDR_BYTE   = {SLV_ADDR, 1'b0};

  typedef enum logic [2:0] {
    IDLE, CMD_ADDR, WAIT_ADDR, CMD_DATA, WAIT_DATA, CMD_STOP, WAIT_STOP, NACK_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [2:0]       retry_cnt_q, retry_cnt_d;
  logic             pending_q, pending_d;
  logic             is_transfer_q, is_transfer_d;
  logic             frame_err_q, frame_err_d;
  logic [9:0]       snap_y_q, snap_y_d;
  logic [7:0]       snap_vy_q, snap_vy_d;
  logic [1:0]       snap_grav_q, snap_grav_d;
  logic             snap_coll_q, snap_coll_d;
  logic [7:0]       payload_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      byte_idx_q    <= '0;
      retry_cnt_q   <= 3'd0;
      pending_q     <= 1'b0;
      is_transfer_q <= 1'b0;
      frame_err_q   <= 1'b0;
      snap_y_q      <= 10'd0;
      snap_vy_q     <= 8'd0;
      snap_grav_q   <= 2'd0;
      snap_coll_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      retry_cnt_q   <= retry_cnt_d;
      pending_q     <= pending_d;
      is_transfer_q <= is_transfer_d;
      frame_err_q   <= frame_err_d;
      snap_y_q      <= snap_y_d;
      snap_vy_q     <= snap_vy_d;
      snap_grav_q   <= snap_grav_d;
      snap_coll_q   <= snap_coll_d;
    end
  end

  // Register layout expected by the peer's 5-register slave receiver.
  always_comb begin
    payload_byte = {7'b0, snap_coll_q};
    case (int'(byte_idx_q))
      0:       payload_byte = snap_y_q[7:0];
      1:       payload_byte = {6'b0, snap_y_q[9:8]};
      2:       payload_byte = snap_vy_q;
      3:       payload_byte = {6'b0, snap_grav_q};
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    retry_cnt_d   = retry_cnt_q;
    pending_d     = pending_q | (ball_send_trigger & is_transfer_q);
    is_transfer_d = is_transfer_q;
    frame_err_d   = frame_err_q;
    snap_y_d      = snap_y_q;
    snap_vy_d     = snap_vy_q;
    snap_grav_d   = snap_grav_q;
    snap_coll_d   = snap_coll_q;
    i2c_en        = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    tx_data       = 8'h00;
    frame_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ball_send_trigger || pending_q) begin
          snap_y_d      = ball_y;
          snap_vy_d     = ball_vy;
          snap_grav_d   = gravity_counter;
          snap_coll_d   = is_collusion;
          pending_d     = 1'b0;
          is_transfer_d = 1'b1;
          frame_err_d   = 1'b0;
          byte_idx_d    = '0;
          retry_cnt_d   = 3'd0;
          state_d       = CMD_ADDR;
        end
      end
      CMD_ADDR: begin
        tx_data = ADDR_BYTE;
        if (ready) begin
          i2c_en  = 1'b1;
          start   = 1'b1;
          state_d = WAIT_ADDR;
        end
      end
      WAIT_ADDR: begin
        tx_data = ADDR_BYTE;
        if (tx_done) state_d = nack ? NACK_STOP : CMD_DATA;
      end
      CMD_DATA: begin
        tx_data = payload_byte;
        if (ready) begin
          i2c_en  = 1'b1;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        tx_data = payload_byte;
        if (tx_done) begin
          if (nack) begin
            state_d = NACK_STOP;
          end else if (byte_idx_q == LAST_IDX) begin
            state_d = CMD_STOP;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            state_d    = CMD_DATA;
          end
        end
      end
      CMD_STOP: begin
        if (ready) begin
          i2c_en  = 1'b1;
          stop    = 1'b1;
          state_d = WAIT_STOP;
        end
      end
      // The master drops ready right after accepting STOP, so ready here means STOP is on the wire.
      WAIT_STOP: begin
        if (ready) begin
          frame_done    = 1'b1;
          is_transfer_d = 1'b0;
          retry_cnt_d   = 3'd0;
          state_d       = IDLE;
        end
      end
      NACK_STOP: begin
        if (ready) begin
          i2c_en = 1'b1;
          stop   = 1'b1;
          if (retry_cnt_q < RETRY_LIMIT) begin
            retry_cnt_d = retry_cnt_q + 3'd1;
            byte_idx_d  = '0;
            state_d     = CMD_ADDR;
          end else begin
            frame_err_d   = 1'b1;
            is_transfer_d = 1'b0;
            retry_cnt_d   = 3'd0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign is_transfer = is_transfer_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ball_frame_i2c_sender.sv
// Directed bench for ball_frame_i2c_sender: a vector table of ball states and NACK scenarios,
// a reactive byte-master model, and hand-written sequences for pending, reset and stall cases.
module tb_ball_frame_i2c_sender;

  localparam logic [7:0] ADDR_BYTE = 8'hD8;
  localparam logic [1:0] K_DATA    = 2'd0;
  localparam logic [1:0] K_STOP    = 2'd1;
  localparam logic [1:0] K_START   = 2'd2;

  logic       clk = 1'b0;
  logic       reset, ball_send_trigger;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic       is_collusion;
  logic       ready, tx_done, nack;
  logic       i2c_en, start, stop;
  logic [7:0] tx_data;
  logic       is_transfer, frame_done, frame_err;

  ball_frame_i2c_sender #(.SLV_ADDR(7'h6C), .MAX_RETRY(2), .N_BYTES(5)) dut (
    .clk(clk), .reset(reset), .ball_send_trigger(ball_send_trigger),
    .ball_y(ball_y), .ball_vy(ball_vy), .gravity_counter(gravity_counter),
    .is_collusion(is_collusion), .ready(ready), .tx_done(tx_done), .nack(nack),
    .i2c_en(i2c_en), .start(start), .stop(stop), .tx_data(tx_data),
    .is_transfer(is_transfer), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]      y;
    logic [7:0]      vy;
    logic [1:0]      g;
    logic            c;
    logic [1:0]      mode;   // 0 = all ACK, 1 = NACK every address, 2 = NACK byte 2 once
    logic [4:0][7:0] pay;
    logic            expDone;
    logic            expErr;
  } vec_t;

  vec_t       vecs[6];
  logic [9:0] cmdLog[$];
  logic [9:0] expQ[$];
  int         testsRun = 0, failCount = 0;
  int         startCnt = 0, doneCnt = 0, dataCnt = 0, lastIdx = 0;
  logic [1:0] lastKind = K_DATA;
  logic       lastEn = 1'b0;
  int         busy = 0, nackMode = 0, startBase = 0, logBase = 0, doneBase = 0;
  logic       stallReq = 1'b0;

  // Command monitor: logs every strobe the DUT issues.
  always begin
    @(negedge clk);
    lastEn = i2c_en && !reset;
    if (frame_done && !reset) doneCnt++;
    if (i2c_en && !reset) begin
      if (start) begin
        lastKind = K_START; startCnt++; dataCnt = 0;
      end else if (stop) begin
        lastKind = K_STOP;
      end else begin
        lastKind = K_DATA; lastIdx = dataCnt; dataCnt++;
      end
      cmdLog.push_back({lastKind, tx_data});
    end
  end

  // Byte-master model: busy 3 cycles per command, tx_done in the last busy cycle for bytes.
  always begin
    @(posedge clk);
    #1;
    tx_done = 1'b0;
    nack    = 1'b0;
    if (reset) begin
      busy = 0;
    end else if (lastEn) begin
      busy = 3;
    end else if (busy > 0) begin
      busy--;
      if (busy == 1 && lastKind != K_STOP) begin
        tx_done = 1'b1;
        nack = (nackMode == 1 && lastKind == K_START) ||
               (nackMode == 2 && lastKind == K_DATA && lastIdx == 2 && startCnt - startBase == 1);
      end
    end
    ready = (busy == 0) && !stallReq;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                                 input logic c, input logic [1:0] mode,
                                 input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                 input logic [7:0] b3, input logic [7:0] b4,
                                 input logic dn, input logic er);
    vec_t v;
    v.y = y; v.vy = vy; v.g = g; v.c = c; v.mode = mode;
    v.pay = {b4, b3, b2, b1, b0};
    v.expDone = dn; v.expErr = er;
    return v;
  endfunction

  task automatic pushFrame(input vec_t v, input int nData);
    expQ.push_back({K_START, ADDR_BYTE});
    for (int i = 0; i < nData; i++) expQ.push_back({K_DATA, v.pay[i]});
    expQ.push_back({K_STOP, 8'h00});
  endtask

  task automatic buildExp(input vec_t v, input int mode);
    if (mode == 1) begin
      for (int k = 0; k < 3; k++) pushFrame(v, 0);
    end else begin
      if (mode == 2) pushFrame(v, 3);
      pushFrame(v, 5);
    end
  endtask

  task automatic compareLog(input string tag);
    int n;
    n = cmdLog.size() - logBase;
    checkOutput({tag, "_cmdCount"}, 64'(n), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < n; i++) begin
      logic [9:0] act;
      act = cmdLog[logBase + i];
      if (expQ[i][9:8] == K_STOP) act[7:0] = 8'h00;
      checkOutput($sformatf("%s_cmd%0d", tag, i), 64'(act), 64'(expQ[i]));
    end
  endtask

  task automatic setInputs(input vec_t v);
    ball_y = v.y; ball_vy = v.vy; gravity_counter = v.g; is_collusion = v.c;
  endtask

  // Trigger from IDLE with an idle master; the START must follow in the very next cycle.
  task automatic fireTrigger(input vec_t v);
    nackMode  = int'(v.mode);
    startBase = startCnt;
    logBase   = cmdLog.size();
    doneBase  = doneCnt;
    setInputs(v);
    ball_send_trigger = 1'b1;
    @(negedge clk);
    ball_send_trigger = 1'b0;
    checkOutput("latency", {61'd0, i2c_en, start, stop} << 8 | 64'(tx_data), {53'd0, 3'b110, ADDR_BYTE});
    checkOutput("busyFlags", {62'd0, is_transfer, frame_err}, 64'b10);
    ball_y = ~v.y; ball_vy = ~v.vy; gravity_counter = ~v.g; is_collusion = ~v.c;
  endtask

  task automatic waitIdle(input int bound);
    int k;
    k = 0;
    while (is_transfer && k < bound) begin @(negedge clk); k++; end
    checkOutput("idleReached", 64'(is_transfer), 64'd0);
  endtask

  task automatic waitDone(input int n, input int bound);
    int k;
    k = 0;
    while (doneCnt - doneBase < n && k < bound) begin @(negedge clk); k++; end
    checkOutput("doneReached", 64'(doneCnt - doneBase >= n), 64'd1);
  endtask

  task automatic waitLog(input int n, input int bound);
    int k;
    k = 0;
    while (cmdLog.size() - logBase < n && k < bound) begin @(negedge clk); k++; end
    checkOutput("logReached", 64'(cmdLog.size() - logBase >= n), 64'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    fireTrigger(v);
    waitIdle(2000);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int stallEn, stallBad;
    reset = 1'b1; ball_send_trigger = 1'b0;
    ball_y = 10'd0; ball_vy = 8'd0; gravity_counter = 2'd0; is_collusion = 1'b0;

    vecs[0] = mkVec(10'h2A5, 8'hF3, 2'b10, 1'b1, 2'd0, 8'hA5, 8'h02, 8'hF3, 8'h02, 8'h01, 1'b1, 1'b0);
    vecs[1] = mkVec(10'h3FF, 8'h00, 2'b11, 1'b0, 2'd0, 8'hFF, 8'h03, 8'h00, 8'h03, 8'h00, 1'b1, 1'b0);
    vecs[2] = mkVec(10'h000, 8'h80, 2'b01, 1'b1, 2'd0, 8'h00, 8'h00, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0);
    vecs[3] = mkVec(10'h155, 8'h7F, 2'b00, 1'b0, 2'd1, 8'h55, 8'h01, 8'h7F, 8'h00, 8'h00, 1'b0, 1'b1);
    vecs[4] = mkVec(10'h0C3, 8'h5A, 2'b10, 1'b1, 2'd0, 8'hC3, 8'h00, 8'h5A, 8'h02, 8'h01, 1'b1, 1'b0);
    vecs[5] = mkVec(10'h1E6, 8'h81, 2'b11, 1'b1, 2'd2, 8'hE6, 8'h01, 8'h81, 8'h03, 8'h01, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("resetOutputs",
                {51'd0, i2c_en, start, stop, tx_data, is_transfer, frame_done, frame_err}, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idleOutputs",
                {51'd0, i2c_en, start, stop, tx_data, is_transfer, frame_done, frame_err}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      expQ.delete();
      buildExp(vecs[i], int'(vecs[i].mode));
      applyStimulus(vecs[i]);
      compareLog($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_doneCount", i), 64'(doneCnt - doneBase), 64'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d_frameErr", i), 64'(frame_err), 64'(vecs[i].expErr));
    end

    // Three triggers during a busy frame merge into one follow-up frame.
    expQ.delete();
    buildExp(vecs[0], 0);
    buildExp(vecs[1], 0);
    fireTrigger(vecs[0]);
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      ball_y = 10'(k * 10'h111);
      ball_send_trigger = 1'b1;
      @(negedge clk);
      ball_send_trigger = 1'b0;
      @(negedge clk);
    end
    setInputs(vecs[1]);
    waitDone(2, 3000);
    repeat (60) @(negedge clk);
    compareLog("pending");
    checkOutput("pending_doneCount", 64'(doneCnt - doneBase), 64'd2);
    checkOutput("pending_idleAfter", 64'(is_transfer), 64'd0);

    // Trigger landing in the frame_done exit cycle is kept as pending.
    expQ.delete();
    buildExp(vecs[2], 0);
    buildExp(vecs[4], 0);
    fireTrigger(vecs[2]);
    begin
      int k;
      k = 0;
      while (!frame_done && k < 2000) begin @(negedge clk); k++; end
    end
    checkOutput("exitTrig_doneSeen", 64'(frame_done), 64'd1);
    setInputs(vecs[4]);
    ball_send_trigger = 1'b1;
    @(negedge clk);
    ball_send_trigger = 1'b0;
    waitDone(2, 3000);
    repeat (10) @(negedge clk);
    compareLog("exitTrig");
    checkOutput("exitTrig_doneCount", 64'(doneCnt - doneBase), 64'd2);

    // Reset while waiting on payload byte 3: no STOP, clean restart afterwards.
    fireTrigger(vecs[2]);
    waitLog(5, 500);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midReset_outputs",
                {51'd0, i2c_en, start, stop, tx_data, is_transfer, frame_done, frame_err}, 64'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midReset_noStop", 64'(cmdLog.size() - logBase), 64'd5);
    expQ.delete();
    buildExp(vecs[2], 0);
    applyStimulus(vecs[2]);
    compareLog("afterReset");
    checkOutput("afterReset_doneCount", 64'(doneCnt - doneBase), 64'd1);

    // Master stalled in CMD_DATA: no strobes, tx_data held, command on first ready cycle.
    expQ.delete();
    buildExp(vecs[4], 0);
    fireTrigger(vecs[4]);
    waitLog(2, 500);
    stallReq = 1'b1;
    repeat (6) @(negedge clk);
    stallEn = 0; stallBad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (i2c_en) stallEn++;
      if (tx_data !== vecs[4].pay[1]) stallBad++;
    end
    checkOutput("stall_noStrobe", 64'(stallEn), 64'd0);
    checkOutput("stall_txStable", 64'(stallBad), 64'd0);
    stallReq = 1'b0;
    @(negedge clk);
    checkOutput("stall_release", {53'd0, i2c_en, start, stop, tx_data}, {53'd0, 3'b100, vecs[4].pay[1]});
    waitIdle(2000);
    repeat (4) @(negedge clk);
    compareLog("stall");
    checkOutput("stall_doneCount", 64'(doneCnt - doneBase), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
